// File: rtl/maze_dfs_if.sv
// Maze RAM port and solution-path stream for the DFS maze engine.
// The master side is the engine; the slave side is the RAM plus the path consumer.
interface maze_dfs_if #(
    parameter int X_W = 4,
    parameter int Y_W = 4
);
    logic [X_W+Y_W-1:0] mem_addr;
    logic               mem_we;
    logic               mem_rdata;
    logic [1:0]         path_dir;
    logic               path_valid;
    logic               path_ready;
    logic               path_last;

    modport master (
        output mem_addr, mem_we, path_dir, path_valid, path_last,
        input  mem_rdata, path_ready
    );

    modport slave (
        input  mem_addr, mem_we, path_dir, path_valid, path_last,
        output mem_rdata, path_ready
    );
endinterface

// File: rtl/maze_dfs_engine.sv
// Depth-first rat-in-maze solver with path stack and valid/ready path readout.
// Optional search cycle budget enabled by defining MAZE_TIMEOUT_EN.
module maze_dfs_engine #(
    parameter int X_W       = 4,
    parameter int Y_W       = 4,
    parameter int STK_DEPTH = 256,
    parameter int TIMEOUT   = 4096,
    localparam int SP_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [X_W-1:0]  start_x,
    input  logic [Y_W-1:0]  start_y,
    input  logic [X_W-1:0]  goal_x,
    input  logic [Y_W-1:0]  goal_y,
    input  logic            run,
    output logic            busy,
    output logic            done,
    output logic            fail,
`ifdef MAZE_TIMEOUT_EN
    output logic            timeout,
`endif
    output logic [SP_W-1:0] path_len,
    maze_dfs_if.master      bus
);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_MARK, S_PROBE, S_WAIT, S_EVAL,
        S_NEXT, S_MOVE, S_BACK, S_DONE, S_READ, S_FAIL
    } state_t;

    state_t          state_reg, state_next;
    logic [X_W-1:0]  x_reg, gx_reg, nx, bx;
    logic [Y_W-1:0]  y_reg, gy_reg, ny, by;
    logic [1:0]      dir_reg, top_dir;
    logic [SP_W-1:0] sp_reg, rd_idx_reg;
    logic            oob, at_goal, stk_full, rd_last;
    logic [1:0]      stack_mem [STK_DEPTH];

    assign at_goal  = (x_reg == gx_reg) && (y_reg == gy_reg);
    assign stk_full = (sp_reg == SP_W'(STK_DEPTH));
    assign rd_last  = (rd_idx_reg == sp_reg - SP_W'(1));
    assign top_dir  = stack_mem[IDX_W'(sp_reg - SP_W'(1))];

    // Neighbour in the current probe direction; also the step taken on MOVE.
    always_comb begin
        nx  = x_reg;
        ny  = y_reg;
        oob = 1'b0;
        case (dir_reg)
            2'd0:    begin oob = (y_reg == '0); ny = y_reg - Y_W'(1); end
            2'd1:    begin oob = (x_reg == '1); nx = x_reg + X_W'(1); end
            2'd2:    begin oob = (x_reg == '0); nx = x_reg - X_W'(1); end
            default: begin oob = (y_reg == '1); ny = y_reg + Y_W'(1); end
        endcase
    end

    // Undo of the step recorded on top of the stack.
    always_comb begin
        bx = x_reg;
        by = y_reg;
        case (top_dir)
            2'd0:    by = y_reg + Y_W'(1);
            2'd1:    bx = x_reg - X_W'(1);
            2'd2:    bx = x_reg + X_W'(1);
            default: by = y_reg - Y_W'(1);
        endcase
    end

`ifdef MAZE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg;
    logic             searching, to_hit, to_reg;

    assign searching = (state_reg inside {S_MARK, S_PROBE, S_WAIT, S_EVAL,
                                          S_NEXT, S_MOVE, S_BACK});
    assign to_hit    = searching && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            to_reg  <= 1'b0;
        end else begin
            to_reg <= to_hit;
            if (state_reg == S_ARM)
                cnt_reg <= '0;
            else if (searching)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign timeout = (state_reg == S_FAIL) && to_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_ARM;
            S_ARM:   if (!start) state_next = S_MARK;
            S_MARK:  state_next = at_goal ? S_DONE : S_PROBE;
            S_PROBE: state_next = oob ? S_NEXT : S_WAIT;
            S_WAIT:  state_next = S_EVAL;
            S_EVAL:  state_next = bus.mem_rdata ? S_NEXT : S_MOVE;
            S_NEXT:  state_next = (dir_reg == 2'd3) ? S_BACK : S_PROBE;
            S_MOVE:  state_next = stk_full ? S_FAIL : S_MARK;
            S_BACK:  state_next = (sp_reg == '0) ? S_FAIL : S_NEXT;
            S_DONE:  if (run) state_next = (sp_reg == '0) ? S_IDLE : S_READ;
            S_READ:  if (bus.path_ready && rd_last) state_next = S_IDLE;
            S_FAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
`ifdef MAZE_TIMEOUT_EN
        if (to_hit) state_next = S_FAIL;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            gx_reg     <= '0;
            gy_reg     <= '0;
            dir_reg    <= '0;
            sp_reg     <= '0;
            rd_idx_reg <= '0;
        end else begin
            case (state_reg)
                S_ARM: if (!start) begin
                    x_reg   <= start_x;
                    y_reg   <= start_y;
                    gx_reg  <= goal_x;
                    gy_reg  <= goal_y;
                    sp_reg  <= '0;
                    dir_reg <= '0;
                end
                S_NEXT: if (dir_reg != 2'd3) dir_reg <= dir_reg + 2'd1;
                S_MOVE: if (!stk_full) begin
                    x_reg   <= nx;
                    y_reg   <= ny;
                    dir_reg <= '0;
                    sp_reg  <= sp_reg + SP_W'(1);
                end
                // Resume probing after the direction we arrived by.
                S_BACK: if (sp_reg != '0) begin
                    x_reg   <= bx;
                    y_reg   <= by;
                    dir_reg <= top_dir;
                    sp_reg  <= sp_reg - SP_W'(1);
                end
                S_DONE: rd_idx_reg <= '0;
                S_READ: if (bus.path_ready) rd_idx_reg <= rd_idx_reg + SP_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == S_MOVE && !stk_full)
            stack_mem[IDX_W'(sp_reg)] <= dir_reg;
    end

    always_comb begin
        busy           = !(state_reg inside {S_IDLE, S_DONE, S_FAIL});
        done           = (state_reg == S_DONE) || (state_reg == S_READ);
        fail           = (state_reg == S_FAIL);
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.path_valid = 1'b0;
        bus.path_last  = 1'b0;
        bus.path_dir   = 2'd0;
        case (state_reg)
            S_MARK: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = {y_reg, x_reg};
            end
            S_PROBE:        if (!oob) bus.mem_addr = {ny, nx};
            S_WAIT, S_EVAL: bus.mem_addr = {ny, nx};
            S_READ: begin
                bus.path_valid = 1'b1;
                bus.path_last  = rd_last;
                bus.path_dir   = stack_mem[IDX_W'(rd_idx_reg)];
            end
            default: ;
        endcase
    end

    assign path_len = sp_reg;
endmodule

// File: tb/tb_maze_dfs_engine.sv
// Randomised and directed bench for maze_dfs_engine on a 16x16 maze with a 32-entry stack.
// Expected paths and visited maps come from a queue-based DFS model of the search rules.
module tb_maze_dfs_engine;
    localparam int X_W = 4, Y_W = 4, STK = 32, N = 16;
    localparam int SP_W = $clog2(STK + 1);

    logic clk = 1'b0;
    logic rst, start, run;
    logic [X_W-1:0] start_x, goal_x;
    logic [Y_W-1:0] start_y, goal_y;
    logic busy, done, fail;
    logic [SP_W-1:0] path_len;
`ifdef MAZE_TIMEOUT_EN
    logic timeout;
`endif
    logic [N*N-1:0] maze_mem;
    int n_pass = 0, n_total = 0, n_fail = 0;

    maze_dfs_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    maze_dfs_engine #(.X_W(X_W), .Y_W(Y_W), .STK_DEPTH(STK), .TIMEOUT(4096)) dut (
        .clk(clk), .rst(rst), .start(start),
        .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
        .run(run), .busy(busy), .done(done), .fail(fail),
`ifdef MAZE_TIMEOUT_EN
        .timeout(timeout),
`endif
        .path_len(path_len), .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read maze RAM; writes only ever set the visited bit.
    always @(posedge clk) begin
        if (bus.mem_we) maze_mem[bus.mem_addr] <= 1'b1;
        bus.mem_rdata <= maze_mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int dxf(input int d);
        return (d == 1) ? 1 : (d == 2) ? -1 : 0;
    endfunction

    function automatic int dyf(input int d);
        return (d == 0) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    // Reference DFS: probe order up,right,left,down; mark on entry; pop and resume after.
    function automatic void ref_solve(input int sx, sy, gx, gy, output bit ok,
                                      output int q[$], output logic [N*N-1:0] vis);
        int x, y, d;
        bit moved;
        vis = maze_mem;
        x = sx; y = sy; d = 0;
        q = {};
        vis[y*N + x] = 1'b1;
        forever begin
            if (x == gx && y == gy) begin ok = 1'b1; return; end
            moved = 1'b0;
            while (d < 4 && !moved) begin
                int tx, ty;
                tx = x + dxf(d);
                ty = y + dyf(d);
                if (tx >= 0 && tx < N && ty >= 0 && ty < N && !vis[ty*N + tx]) moved = 1'b1;
                else d++;
            end
            if (moved) begin
                if (q.size() == STK) begin ok = 1'b0; return; end
                q.push_back(d);
                x += dxf(d); y += dyf(d);
                vis[y*N + x] = 1'b1;
                d = 0;
            end else begin
                if (q.size() == 0) begin ok = 1'b0; return; end
                d = q.pop_back();
                x -= dxf(d); y -= dyf(d);
                d++;
            end
        end
    endfunction

    task automatic chk_quiet(input string tag);
        chk(tag, {busy, done, fail, bus.path_valid, bus.path_last, bus.path_dir,
                  bus.mem_we, bus.mem_addr, path_len}, 0);
    endtask

    // rdy_mode: 0 always ready, 1 toggle every cycle, 2 random. abort: reset after first beat.
    task automatic do_search(input string tag, input int sx, sy, gx, gy,
                             input int rdy_mode, input bit abort);
        bit ok;
        int q[$];
        logic [N*N-1:0] vis;
        int cyc, beats;
        ref_solve(sx, sy, gx, gy, ok, q, vis);
        start_x = X_W'(sx); start_y = Y_W'(sy);
        goal_x  = X_W'(gx); goal_y  = Y_W'(gy);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && !fail && cyc < 8000);
        $display("search %s start=(%0d,%0d) goal=(%0d,%0d) model_ok=%0d len=%0d cycles=%0d",
                 tag, sx, sy, gx, gy, ok, q.size(), cyc);
        chk({tag, "_outcome"}, {done, fail}, ok ? 2'b10 : 2'b01);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_visited"}, maze_mem == vis, 1);
        if (!ok) begin
            @(negedge clk);
            chk({tag, "_fail_pulse"}, {fail, busy}, 0);
            return;
        end
        chk({tag, "_len"}, path_len, q.size());
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        beats = 0; cyc = 0;
        while (beats < q.size() && cyc < 4000) begin
            bus.path_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom);
            if (bus.path_valid && bus.path_ready) begin
                chk({tag, "_dir"}, bus.path_dir, q[beats]);
                chk({tag, "_last"}, bus.path_last, beats == q.size() - 1);
                beats++;
            end else if (q.size() > 0) begin
                chk({tag, "_hold_valid"}, bus.path_valid, 1);
            end
            if (abort && beats == 1) begin
                rst = 1'b1;
                @(negedge clk);
                chk_quiet({tag, "_rst_read"});
                rst = 1'b0;
                bus.path_ready = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        bus.path_ready = 1'b0;
        chk({tag, "_beats"}, beats, q.size());
        chk({tag, "_after"}, {bus.path_valid, done, busy}, 0);
    endtask

    task automatic open_box(input int ox, oy, w, h, input int density);
        maze_mem = '1;
        for (int yy = oy; yy < oy + h; yy++)
            for (int xx = ox; xx < ox + w; xx++)
                maze_mem[yy*N + xx] = ($urandom_range(99) < density);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; run = 1'b0;
        start_x = '0; start_y = '0; goal_x = '0; goal_y = '0;
        bus.path_ready = 1'b0;
        maze_mem = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset_idle");

        open_box(0, 0, 4, 4, 0);
        do_search("open4x4", 0, 0, 3, 3, 1, 1'b0);

        open_box(0, 0, 4, 4, 0);
        do_search("same_cell", 2, 2, 2, 2, 0, 1'b0);
        @(negedge clk);
        chk("same_cell_no_beats", {bus.path_valid, done, busy}, 0);

        maze_mem = '0;
        maze_mem[4*N + 5] = 1'b1; maze_mem[5*N + 6] = 1'b1;
        maze_mem[5*N + 4] = 1'b1; maze_mem[6*N + 5] = 1'b1;
        do_search("walled", 5, 5, 0, 0, 0, 1'b0);

        // Corridor right from (0,0) is a dead end; goal is down the left column.
        maze_mem = '1;
        for (int i = 0; i < 4; i++) begin
            maze_mem[i] = 1'b0;
            maze_mem[i*N] = 1'b0;
        end
        do_search("dead_end", 0, 0, 0, 3, 2, 1'b0);
        chk("dead_end_marked", maze_mem[3], 1);

        maze_mem = '0;
        do_search("overflow", 0, 0, 15, 15, 0, 1'b0);

        for (int it = 0; it < 10; it++) begin
            int ox, oy, sx, sy, gx, gy;
            ox = (it % 2) * 8;
            oy = ((it / 2) % 2) * 8;
            open_box(ox, oy, 8, 8, 30);
            sx = ox + $urandom_range(7); sy = oy + $urandom_range(7);
            gx = ox + $urandom_range(7); gy = oy + $urandom_range(7);
            maze_mem[sy*N + sx] = 1'b0;
            maze_mem[gy*N + gx] = 1'b0;
            do_search($sformatf("rand%0d", it), sx, sy, gx, gy, 2, 1'b0);
        end

        open_box(0, 0, 4, 4, 0);
        do_search("rst_in_read", 0, 0, 3, 3, 0, 1'b1);
        @(negedge clk);
        chk_quiet("post_abort_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
